// File: rtl/bp_pkg.sv
// Shared encodings and constants for the branch predictor.
// Imported by the BTB/RAS top and the replacement LFSR.
package bp_pkg;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_DIR  = 2'd1,
      BR_CALL = 2'd2,
      BR_RET  = 2'd3
   } br_type_t;

   // Sized for the deepest supported stack; narrower configs use the low bits.
   localparam int RAS_PTR_MAX_W = 5;

   typedef struct packed {
      logic [RAS_PTR_MAX_W-1:0] ras_ptr;
      logic [RAS_PTR_MAX_W:0]   ras_cnt;
   } ras_ckpt_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/bp_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
// Shared by replacement logic that needs a pseudo-random victim.
module bp_lfsr8
   import bp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] out
);

   always_ff @(posedge clk) begin
      if (reset) out <= LFSR_SEED;
      else       out <= {out[6:0], ^(out & LFSR_TAPS)};
   end

endmodule

// File: rtl/btb_ras_pred.sv
// Fully-associative BTB with a wrapping return-address stack.
// Registered prediction; RAS pointer repaired from checkpoints on flush.
module btb_ras_pred
   import bp_pkg::*;
#(
   parameter int BTB_ENTRIES = 32,
   parameter int CNT_W       = 2,
   parameter int RAS_DEPTH   = 8,
   localparam int IDX_W      = $clog2(BTB_ENTRIES),
   localparam int RP_W       = $clog2(RAS_DEPTH),
   localparam int CK_W       = 2*RP_W+1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_en,
   input  logic [31:0]      fetch_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   output logic [IDX_W-1:0] pred_index,
   output logic [CK_W-1:0]  pred_ras_ckpt,
   input  logic             upd_en,
   input  logic [31:0]      upd_pc,
   input  logic             upd_hit,
   input  logic [IDX_W-1:0] upd_index,
   input  logic             upd_is_br,
   input  logic [1:0]       upd_type,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             flush_en,
   input  logic [CK_W-1:0]  flush_ckpt
);

   localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W-1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [RP_W:0]    RAS_FULL = (RP_W+1)'(RAS_DEPTH);

   logic [BTB_ENTRIES-1:0] valid;
   logic [29:0]            tag [BTB_ENTRIES];
   logic [29:0]            tgt [BTB_ENTRIES];
   logic [CNT_W-1:0]       cnt [BTB_ENTRIES];
   logic [1:0]             typ [BTB_ENTRIES];

   logic [29:0]   ras [RAS_DEPTH];
   logic [RP_W-1:0] ras_ptr;
   logic [RP_W:0]   ras_cnt;

   logic [7:0] lfsr;

   bp_lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .out   (lfsr)
   );

   logic [BTB_ENTRIES-1:0] match;
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic [29:0]            hit_tgt;
   logic [CNT_W-1:0]       hit_cnt;
   logic [1:0]             hit_typ;
   logic [29:0]            ras_top;
   logic                   look_taken;
   logic [29:0]            look_tgt;

   // Match vector is one-hot by construction, so OR-reduce the fields.
   always_comb begin
      match   = '0;
      hit_idx = '0;
      hit_tgt = '0;
      hit_cnt = '0;
      hit_typ = '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
         match[i] = valid[i] && (tag[i] == fetch_pc[31:2]);
         if (match[i]) begin
            hit_idx = hit_idx | IDX_W'(i);
            hit_tgt = hit_tgt | tgt[i];
            hit_cnt = hit_cnt | cnt[i];
            hit_typ = hit_typ | typ[i];
         end
      end
      hit = |match;
   end

   assign ras_top    = ras[ras_ptr - RP_W'(1)];
   assign look_taken = (hit_typ == BR_COND) ? hit_cnt[CNT_W-1] : 1'b1;
   assign look_tgt   = (hit_typ == BR_RET && ras_cnt != '0) ? ras_top : hit_tgt;

   logic [IDX_W-1:0] free_idx;
   logic             any_free;
   logic [IDX_W-1:0] alloc_slot;

   always_comb begin
      free_idx = '0;
      for (int i = BTB_ENTRIES-1; i >= 0; i--) begin
         if (!valid[i]) free_idx = IDX_W'(i);
      end
   end

   assign any_free   = ~&valid;
   assign alloc_slot = any_free ? free_idx : lfsr[IDX_W-1:0];

   logic do_inv, do_alloc, do_retgt, do_train, do_push, do_pop;

   assign do_inv   = upd_en && upd_hit && !upd_is_br;
   assign do_alloc = upd_en && !upd_hit && upd_is_br &&
                     (upd_taken || upd_type != BR_COND);
   assign do_retgt = upd_en && upd_hit && upd_is_br &&
                     upd_type != BR_RET && upd_taken &&
                     tgt[upd_index] != upd_target[31:2];
   assign do_train = upd_en && upd_hit && upd_is_br &&
                     upd_type == BR_COND;
   assign do_push  = upd_en && upd_is_br && upd_type == BR_CALL;
   assign do_pop   = upd_en && upd_is_br && upd_type == BR_RET;

   always_ff @(posedge clk) begin
      if (reset)         valid <= '0;
      else if (do_inv)   valid[upd_index] <= 1'b0;
      else if (do_alloc) valid[alloc_slot] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_alloc) begin
         tag[alloc_slot] <= upd_pc[31:2];
         tgt[alloc_slot] <= upd_target[31:2];
         typ[alloc_slot] <= upd_type;
         cnt[alloc_slot] <= CNT_WEAK;
      end else if (do_retgt) begin
         tgt[upd_index] <= upd_target[31:2];
         typ[upd_index] <= upd_type;
         cnt[upd_index] <= CNT_WEAK;
      end else if (do_train) begin
         if (upd_taken) begin
            if (cnt[upd_index] != CNT_MAX)
               cnt[upd_index] <= cnt[upd_index] + CNT_W'(1);
         end else if (cnt[upd_index] != '0) begin
            cnt[upd_index] <= cnt[upd_index] - CNT_W'(1);
         end
      end
   end

   // Flush repairs only the pointer pair; stack contents stay as they are.
   always_ff @(posedge clk) begin
      if (reset) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (flush_en) begin
         {ras_ptr, ras_cnt} <= flush_ckpt;
      end else if (do_push) begin
         ras[ras_ptr] <= upd_pc[31:2] + 30'd1;
         ras_ptr      <= ras_ptr + RP_W'(1);
         if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + (RP_W+1)'(1);
      end else if (do_pop && ras_cnt != '0) begin
         ras_ptr <= ras_ptr - RP_W'(1);
         ras_cnt <= ras_cnt - (RP_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid    <= 1'b0;
         pred_taken    <= 1'b0;
         pred_target   <= '0;
         pred_index    <= '0;
         pred_ras_ckpt <= '0;
      end else if (fetch_en) begin
         pred_valid    <= hit;
         pred_taken    <= hit && look_taken;
         pred_target   <= hit ? {look_tgt, 2'b00} : 32'd0;
         pred_index    <= hit_idx;
         pred_ras_ckpt <= {ras_ptr, ras_cnt};
      end
   end

   logic unused_bits;
   assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0], lfsr};

endmodule

// File: tb/tb_btb_ras_pred.sv
// Directed bench for btb_ras_pred: vector table plus
// replacement, RAS wrap and checkpoint-repair sequences.
module tb_btb_ras_pred;

   localparam logic [1:0] T_COND = 2'd0;
   localparam logic [1:0] T_DIR  = 2'd1;
   localparam logic [1:0] T_CALL = 2'd2;
   localparam logic [1:0] T_RET  = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] fetch_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [4:0]  pred_index;
   logic [6:0]  pred_ras_ckpt;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_hit;
   logic [4:0]  upd_index;
   logic        upd_is_br;
   logic [1:0]  upd_type;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush_en;
   logic [6:0]  flush_ckpt;

   btb_ras_pred #(
      .BTB_ENTRIES (32),
      .CNT_W       (2),
      .RAS_DEPTH   (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .fetch_pc      (fetch_pc),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_index    (pred_index),
      .pred_ras_ckpt (pred_ras_ckpt),
      .upd_en        (upd_en),
      .upd_pc        (upd_pc),
      .upd_hit       (upd_hit),
      .upd_index     (upd_index),
      .upd_is_br     (upd_is_br),
      .upd_type      (upd_type),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target),
      .flush_en      (flush_en),
      .flush_ckpt    (flush_ckpt)
   );

   always #5 clk = ~clk;

   // Reference replacement LFSR: x^8+x^6+x^5+x^4+1, seed A5.
   logic [7:0] lfsr_m;
   always @(posedge clk) begin
      if (reset) lfsr_m <= 8'hA5;
      else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   int pass_n  = 0;
   int total_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic hit, input logic [4:0] idx,
                          input logic br, input logic [1:0] ty, input logic tk,
                          input logic [31:0] tg);
      upd_en     = 1'b1;
      upd_pc     = pc;
      upd_hit    = hit;
      upd_index  = idx;
      upd_is_br  = br;
      upd_type   = ty;
      upd_taken  = tk;
      upd_target = tg;
   endtask

   task automatic do_upd(input logic [31:0] pc, input logic hit, input logic [4:0] idx,
                         input logic br, input logic [1:0] ty, input logic tk,
                         input logic [31:0] tg);
      set_upd(pc, hit, idx, br, ty, tk, tg);
      tick();
      upd_en = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      fetch_en = 1'b1;
      fetch_pc = pc;
      tick();
      fetch_en = 1'b0;
   endtask

   typedef struct {
      logic        fe;
      logic [31:0] fpc;
      logic        ue;
      logic [31:0] upc;
      logic        uhit;
      logic [4:0]  uidx;
      logic        ubr;
      logic [1:0]  utyp;
      logic        utk;
      logic [31:0] utgt;
      logic        ev;
      logic        et;
      logic [31:0] etgt;
      logic [4:0]  eidx;
   } vec_t;

   localparam logic [31:0] PA  = 32'h1C00_0000;
   localparam logic [31:0] PB  = 32'h1C00_0040;
   localparam logic [31:0] TA  = 32'h1C00_0100;
   localparam logic [31:0] TB  = 32'h1C00_0800;
   localparam logic [31:0] TB2 = 32'h1C00_0C00;

   vec_t        tbl [21];
   logic [31:0] slot_pc [32];
   logic [4:0]  victim;
   logic [31:0] xpc;

   initial begin
      reset    = 1'b1;
      fetch_en = 1'b0;
      fetch_pc = '0;
      upd_en   = 1'b0;
      upd_pc   = '0;
      upd_hit  = 1'b0;
      upd_index = '0;
      upd_is_br = 1'b0;
      upd_type  = '0;
      upd_taken = 1'b0;
      upd_target = '0;
      flush_en   = 1'b0;
      flush_ckpt = '0;

      tbl[0]  = '{1'b1, PA, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_DIR,  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0};
      tbl[1]  = '{1'b1, PA, 1'b1, PA,    1'b0, 5'd0, 1'b1, T_DIR,  1'b1, TA,    1'b0, 1'b0, 32'h0, 5'd0};
      tbl[2]  = '{1'b1, PA, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_DIR,  1'b0, 32'h0, 1'b1, 1'b1, TA,    5'd0};
      tbl[3]  = '{1'b1, PB, 1'b1, PB,    1'b0, 5'd0, 1'b1, T_COND, 1'b1, TB,    1'b0, 1'b0, 32'h0, 5'd0};
      tbl[4]  = '{1'b1, PB, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_COND, 1'b0, 32'h0, 1'b1, 1'b1, TB,    5'd1};
      tbl[5]  = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b0, TB,    1'b1, 1'b1, TB,    5'd1};
      tbl[6]  = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b0, TB,    1'b1, 1'b0, TB,    5'd1};
      tbl[7]  = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b0, TB,    1'b1, 1'b0, TB,    5'd1};
      tbl[8]  = '{1'b1, PB, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_COND, 1'b0, 32'h0, 1'b1, 1'b0, TB,    5'd1};
      tbl[9]  = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b1, TB,    1'b1, 1'b0, TB,    5'd1};
      tbl[10] = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b1, TB,    1'b1, 1'b0, TB,    5'd1};
      tbl[11] = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b1, TB,    1'b1, 1'b1, TB,    5'd1};
      tbl[12] = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b1, TB,    1'b1, 1'b1, TB,    5'd1};
      tbl[13] = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b0, TB,    1'b1, 1'b1, TB,    5'd1};
      tbl[14] = '{1'b1, PB, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_COND, 1'b0, 32'h0, 1'b1, 1'b1, TB,    5'd1};
      tbl[15] = '{1'b1, PB, 1'b1, PB,    1'b1, 5'd1, 1'b1, T_COND, 1'b1, TB2,   1'b1, 1'b1, TB,    5'd1};
      tbl[16] = '{1'b1, PB, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_COND, 1'b0, 32'h0, 1'b1, 1'b1, TB2,   5'd1};
      tbl[17] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_COND, 1'b0, 32'h0, 1'b1, 1'b1, TB2, 5'd1};
      tbl[18] = '{1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_COND, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0};
      tbl[19] = '{1'b1, PA, 1'b1, PA,    1'b1, 5'd0, 1'b0, T_DIR,  1'b0, 32'h0, 1'b1, 1'b1, TA,    5'd0};
      tbl[20] = '{1'b1, PA, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, T_DIR,  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0};

      repeat (3) tick();
      chk("rst_valid",  32'(pred_valid), 32'd0);
      chk("rst_taken",  32'(pred_taken), 32'd0);
      chk("rst_target", pred_target, 32'd0);
      chk("rst_index",  32'(pred_index), 32'd0);
      chk("rst_ckpt",   32'(pred_ras_ckpt), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         fetch_en = tbl[i].fe;
         fetch_pc = tbl[i].fpc;
         if (tbl[i].ue)
            set_upd(tbl[i].upc, tbl[i].uhit, tbl[i].uidx, tbl[i].ubr,
                    tbl[i].utyp, tbl[i].utk, tbl[i].utgt);
         tick();
         upd_en   = 1'b0;
         fetch_en = 1'b0;
         chk($sformatf("v%0d_valid", i), 32'(pred_valid), 32'(tbl[i].ev));
         chk($sformatf("v%0d_taken", i), 32'(pred_taken), 32'(tbl[i].et));
         chk($sformatf("v%0d_target", i), pred_target, tbl[i].etgt);
         chk($sformatf("v%0d_index", i), 32'(pred_index), 32'(tbl[i].eidx));
      end

      // Fill: slot 1 already holds PB, slot 0 was freed by the alias row.
      slot_pc[1] = PB;
      for (int k = 0; k < 31; k++) begin
         do_upd(32'h4000_0000 + 32'(4*k), 1'b0, 5'd0, 1'b1, T_DIR, 1'b1,
                32'h5000_0000 + 32'(4*k));
         slot_pc[(k == 0) ? 0 : k+1] = 32'h4000_0000 + 32'(4*k);
      end
      look(32'h4000_0000 + 32'd40);
      chk("fill_valid", 32'(pred_valid), 32'd1);
      chk("fill_index", 32'(pred_index), 32'd11);
      chk("fill_target", pred_target, 32'h5000_0028);

      xpc = 32'h4000_0000 + 32'd124;
      set_upd(xpc, 1'b0, 5'd0, 1'b1, T_DIR, 1'b1, 32'h6000_0000);
      victim = lfsr_m[4:0];
      tick();
      upd_en = 1'b0;
      look(xpc);
      chk("victim_valid", 32'(pred_valid), 32'd1);
      chk("victim_index", 32'(pred_index), 32'(victim));
      look(slot_pc[victim]);
      chk("evicted_miss", 32'(pred_valid), 32'd0);
      slot_pc[victim] = xpc;

      do_upd(slot_pc[5], 1'b1, 5'd5, 1'b0, T_DIR, 1'b0, 32'h0);
      look(slot_pc[5]);
      chk("alias_inv", 32'(pred_valid), 32'd0);
      do_upd(32'h4000_1000, 1'b0, 5'd0, 1'b1, T_DIR, 1'b1, 32'h7000_0000);
      look(32'h4000_1000);
      chk("realloc_valid", 32'(pred_valid), 32'd1);
      chk("realloc_index", 32'(pred_index), 32'd5);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_valid", 32'(pred_valid), 32'd0);
      look(32'h4000_1000);
      chk("midrst_miss", 32'(pred_valid), 32'd0);
      look(PB);
      chk("midrst_miss2", 32'(pred_valid), 32'd0);

      // RAS wrap: 9 calls into an 8-deep stack.
      do_upd(32'h3000, 1'b0, 5'd0, 1'b1, T_RET, 1'b1, 32'h5000);
      for (int k = 1; k <= 9; k++)
         do_upd(32'(k * 32'h100), 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      look(32'h3000);
      chk("ras9_valid",  32'(pred_valid), 32'd1);
      chk("ras9_taken",  32'(pred_taken), 32'd1);
      chk("ras9_index",  32'(pred_index), 32'd0);
      chk("ras9_target", pred_target, 32'h904);
      chk("ras9_ckpt",   32'(pred_ras_ckpt), 32'h18);

      repeat (7) do_upd(32'h3000, 1'b1, 5'd0, 1'b1, T_RET, 1'b1, 32'h5000);
      look(32'h3000);
      chk("pop7_target", pred_target, 32'h204);
      chk("pop7_ckpt",   32'(pred_ras_ckpt), 32'h21);
      do_upd(32'h3000, 1'b1, 5'd0, 1'b1, T_RET, 1'b1, 32'h5000);
      look(32'h3000);
      chk("pop8_target", pred_target, 32'h5000);
      chk("pop8_ckpt",   32'(pred_ras_ckpt), 32'h10);
      do_upd(32'h3000, 1'b1, 5'd0, 1'b1, T_RET, 1'b1, 32'h5000);
      look(32'h3000);
      chk("pop9_target", pred_target, 32'h5000);
      chk("pop9_ckpt",   32'(pred_ras_ckpt), 32'h10);

      // Checkpoint repair.
      do_upd(32'hA00, 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      do_upd(32'hB00, 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      look(32'h3000);
      chk("ck2_ckpt",   32'(pred_ras_ckpt), 32'h32);
      chk("ck2_target", pred_target, 32'hB04);
      do_upd(32'hC00, 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      do_upd(32'hD00, 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      do_upd(32'hE00, 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      do_upd(32'h3000, 1'b1, 5'd0, 1'b1, T_RET, 1'b1, 32'h5000);
      look(32'h3000);
      chk("ck5_ckpt",   32'(pred_ras_ckpt), 32'h54);
      chk("ck5_target", pred_target, 32'hD04);

      flush_en   = 1'b1;
      flush_ckpt = 7'h32;
      fetch_en   = 1'b1;
      fetch_pc   = 32'h3000;
      set_upd(32'hF00, 1'b0, 5'd0, 1'b1, T_CALL, 1'b1, 32'h8000);
      tick();
      flush_en = 1'b0;
      fetch_en = 1'b0;
      upd_en   = 1'b0;
      chk("flushcyc_ckpt",   32'(pred_ras_ckpt), 32'h54);
      chk("flushcyc_target", pred_target, 32'hD04);
      look(32'h3000);
      chk("flush_ckpt",   32'(pred_ras_ckpt), 32'h32);
      chk("flush_target", pred_target, 32'hB04);
      look(32'hF00);
      chk("flush_btb_valid",  32'(pred_valid), 32'd1);
      chk("flush_btb_index",  32'(pred_index), 32'd15);
      chk("flush_btb_target", pred_target, 32'h8000);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
